// File: rtl/dino_game_sequencer_if.sv
// Signal bundle between the dino game sequencer and its neighbours:
// button and collision inputs in; frame, cactus, jump, display and sound outputs.
interface dino_game_sequencer_if;
  logic        up;
  logic        collision;
  logic        frame_tick;
  logic        cactus_en;
  logic        jump_en;
  logic [1:0]  game_state;
  logic [15:0] score;
  logic [2:0]  level;
  logic        sound_trig;

  // Sequencer side: consumes button/collision, drives all game outputs.
  modport master (
    input  up,
    input  collision,
    output frame_tick,
    output cactus_en,
    output jump_en,
    output game_state,
    output score,
    output level,
    output sound_trig
  );

  // Surrounding blocks: supply button/collision, observe game outputs.
  modport slave (
    output up,
    output collision,
    input  frame_tick,
    input  cactus_en,
    input  jump_en,
    input  game_state,
    input  score,
    input  level,
    input  sound_trig
  );
endinterface

// File: rtl/dino_game_sequencer.sv
// Game-phase controller for the dino runner: start/run/over/armed state
// machine, frame tick generation, cactus step scheduling that speeds up
// with level, BCD score keeping and sound trigger pulses.
module dino_game_sequencer #(
  parameter int FRAME_DIV   = 200000,
  parameter int BASE_PERIOD = 8,
  parameter int MAX_LEVEL   = 7,
  parameter int HOLD_FRAMES = 60
) (
  input  logic                  clk,
  input  logic                  rst,
  dino_game_sequencer_if.master bus
);

  localparam int DIV_W  = (FRAME_DIV   > 1) ? $clog2(FRAME_DIV)   : 1;
  localparam int MOVE_W = (BASE_PERIOD > 1) ? $clog2(BASE_PERIOD) : 1;
  localparam int HOLD_W = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(FRAME_DIV - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_FRAMES - 1);
  localparam logic [2:0]        LEVEL_MAX = 3'(MAX_LEVEL);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_OVER  = 2'd2,
    S_ARMED = 2'd3
  } state_t;

  state_t             state_q,      state_d;
  logic [DIV_W-1:0]   div_cnt_q,    div_cnt_d;
  logic [MOVE_W-1:0]  move_cnt_q,   move_cnt_d;
  logic [HOLD_W-1:0]  hold_cnt_q,   hold_cnt_d;
  logic [15:0]        score_q,      score_d;
  logic [2:0]         level_q,      level_d;
  logic               up_prev_q;
  logic               frame_tick_q, frame_tick_d;
  logic               cactus_en_q,  cactus_en_d;
  logic               sound_trig_q, sound_trig_d;
  logic               jump_en_q,    jump_en_d;

  logic               tick_now;
  logic               up_rise;
  logic               move_wrap;

  // Last move_cnt value of a cactus step for each level: P-1 with
  // P = max(1, BASE_PERIOD - level). All entries are elaboration constants.
  logic [MOVE_W-1:0]  period_last_lut [8];

  for (genvar gi = 0; gi < 8; gi++) begin : g_period
    localparam int LAST = (BASE_PERIOD - 1 - gi > 0) ? (BASE_PERIOD - 1 - gi) : 0;
    assign period_last_lut[gi] = MOVE_W'(LAST);
  end

  // Four-digit BCD increment with ripple carry across the nibbles.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        c;
    r = v;
    c = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (c) begin
        if (v[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = v[i*4 +: 4] + 4'd1;
          c = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick_now  = (div_cnt_q == DIV_LAST);
  assign up_rise   = bus.up & ~up_prev_q;
  // ">=" rather than "==": after a level-up shortens P, a counter already
  // past the new last value still fires on the very next frame.
  assign move_wrap = (move_cnt_q >= period_last_lut[level_q]);

  // Next-state and output decode for the game state machine.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = tick_now ? '0 : div_cnt_q + 1'b1;
    move_cnt_d   = move_cnt_q;
    hold_cnt_d   = hold_cnt_q;
    score_d      = score_q;
    level_d      = level_q;
    frame_tick_d = tick_now;
    cactus_en_d  = 1'b0;
    sound_trig_d = 1'b0;

    case (state_q)
      S_IDLE, S_ARMED: begin
        // Collision is not looked at here, so a start on the same edge wins.
        if (up_rise) begin
          state_d    = S_RUN;
          score_d    = '0;
          level_d    = '0;
          move_cnt_d = '0;
        end
      end

      S_RUN: begin
        if (bus.collision) begin
          // Collision pre-empts the frame update on this edge.
          state_d      = S_OVER;
          hold_cnt_d   = '0;
          sound_trig_d = 1'b1;
        end else if (tick_now) begin
          if (score_q != 16'h9999) begin
            score_d = bcd_inc(score_q);
            // Low two digits rolling 99 -> 00 marks a new hundred.
            if ((score_q[7:0] == 8'h99) && (level_q < LEVEL_MAX)) begin
              level_d      = level_q + 3'd1;
              sound_trig_d = 1'b1;
            end
          end
          // Step period uses the level in force during the frame that ended.
          if (move_wrap) begin
            move_cnt_d  = '0;
            cactus_en_d = 1'b1;
          end else begin
            move_cnt_d  = move_cnt_q + 1'b1;
          end
        end
      end

      S_OVER: begin
        // Frozen display; the button is ignored until the hold expires.
        if (tick_now) begin
          if (hold_cnt_q == HOLD_LAST) begin
            state_d = S_ARMED;
          end else begin
            hold_cnt_d = hold_cnt_q + 1'b1;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    jump_en_d = (state_d == S_RUN);
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      div_cnt_q    <= '0;
      move_cnt_q   <= '0;
      hold_cnt_q   <= '0;
      score_q      <= '0;
      level_q      <= '0;
      up_prev_q    <= 1'b1;  // a button held through reset must not start a game
      frame_tick_q <= 1'b0;
      cactus_en_q  <= 1'b0;
      sound_trig_q <= 1'b0;
      jump_en_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      move_cnt_q   <= move_cnt_d;
      hold_cnt_q   <= hold_cnt_d;
      score_q      <= score_d;
      level_q      <= level_d;
      up_prev_q    <= bus.up;
      frame_tick_q <= frame_tick_d;
      cactus_en_q  <= cactus_en_d;
      sound_trig_q <= sound_trig_d;
      jump_en_q    <= jump_en_d;
    end
  end

  assign bus.frame_tick = frame_tick_q;
  assign bus.cactus_en  = cactus_en_q;
  assign bus.jump_en    = jump_en_q;
  assign bus.game_state = state_q;
  assign bus.score      = score_q;
  assign bus.level      = level_q;
  assign bus.sound_trig = sound_trig_q;

endmodule

// File: doc/dino_game_sequencer.md
# dino_game_sequencer

Game-phase controller for the dino runner. It owns the start / run / game-over state machine, generates the frame tick, schedules cactus movement steps at a speed that rises with score, and keeps the BCD score. It sits between the synchronized `up` button and the collision detector on the input side, and the jump, cactus-move, display and sound blocks on the output side.

## Interface
Parameters:
- `FRAME_DIV`, default 200000: clk cycles per frame (12 MHz / 60 Hz).
- `BASE_PERIOD`, default 8: frames per cactus step at level 0.
- `MAX_LEVEL`, default 7: maximum speed level.
- `HOLD_FRAMES`, default 60: frames frozen in OVER before a restart is accepted.

Ports:
- `clk` in 1: system clock.
- `rst` in 1: reset. Synchronous, active-high.
- `up` in 1: jump/start button, already synchronized, level.
- `collision` in 1: collision detector output, level.
- `frame_tick` out 1: one-cycle pulse per frame.
- `cactus_en` out 1: one-cycle pulse; cactus advances one step.
- `jump_en` out 1: high while in RUN.
- `game_state` out 2: 0=IDLE, 1=RUN, 2=OVER, 3=ARMED.
- `score` out 16: four BCD digits, [15:12] thousands.
- `level` out 3: current speed level.
- `sound_trig` out 1: one-cycle pulse to the DAC tone block.

## Operation
Internal state:
- `div_cnt` (0..FRAME_DIV-1) free-runs in all states.
- `tick_now` = (div_cnt == FRAME_DIV-1).
- `up_prev` register; `up_rise` = up & ~up_prev.
- `move_cnt` counts frames between cactus steps.
- `hold_cnt` counts OVER frames.
- Cactus step period P = max(1, BASE_PERIOD − level).

State machine:
- IDLE: on `up_rise`, go to RUN. Clear score, level, move_cnt.
- RUN:
  - `collision`=1 at an edge: go to OVER, clear hold_cnt, pulse sound_trig. Collision has priority: on that edge score does not increment and cactus_en stays low.
  - Otherwise, on `tick_now`: score increments by 1 in BCD and saturates at 9999.
  - Also on `tick_now`: if move_cnt == P−1, set move_cnt to 0 and assert cactus_en; else increment move_cnt.
- Level rule: when a score increment carries the tens/ones digits to 00 and level < MAX_LEVEL, level increments and sound_trig pulses. Level never wraps.
- OVER: score, level and cactus frozen. hold_cnt increments on `tick_now`; when it reaches HOLD_FRAMES−1 on a tick, go to ARMED. `up` is ignored.
- ARMED: on `up_rise`, go to RUN. Clear score, level, move_cnt.

Output rules:
- jump_en = (game_state == RUN), registered.
- If level changes, the new P applies from the next frame. If move_cnt ≥ new P−1, the next tick fires cactus_en.

## Timing
- All outputs are registered.
- Reset values: div_cnt=0, move_cnt=0, hold_cnt=0, state IDLE, score=0000, level=0, all pulses 0, jump_en=0.
- `up_prev` resets to 1, so a button held through reset does not start the game.
- `rst` mid-game returns to IDLE on the next edge regardless of state; no pending pulses survive.
- Edge where `tick_now` holds:
  - div_cnt → 0.
  - frame_tick high for the following cycle.
  - score/level/cactus_en updated on the same edge, visible in that cycle.
- frame_tick period is exactly FRAME_DIV cycles. cactus_en is always coincident with a frame_tick.
- State transition latency: one edge after the qualifying input (`up_rise` or `collision`).
- `up_rise` and `collision` asserted on the same edge in IDLE/ARMED: the start wins, and collision is evaluated from the next edge.
- Score width: 16 bits, each nibble 0..9; no binary overflow is possible.

## Test plan
Use FRAME_DIV=4, BASE_PERIOD=3, MAX_LEVEL=2, HOLD_FRAMES=2.
- Reset with up=1 held, release, press again → game_state stays 0 until the second rising edge. jump_en goes to 1 one cycle after that edge. score=0000.
- RUN for 12 frames, no collision → frame_tick every 4 cycles. cactus_en on every 3rd frame_tick. score=0012.
- RUN to 100 frames, then to 200 → level 0→1 at score 0100 and 1→2 at 0200, each with a one-cycle sound_trig. cactus_en on every frame_tick after level 2 (P=1). At score 0300, level stays 2.
- collision=1 on a tick_now edge at score 0041 → game_state=2. score stays 0041. No cactus_en. One sound_trig. jump_en=0.
- In OVER, press up → ignored. After 2 frame_ticks, game_state=3. up rising edge → RUN with score=0000, level=0.
- Assert rst for one cycle mid-RUN at score 0057 → next cycle: IDLE, score=0000, all pulses 0.
